pe_mac_sequencer: RTL and testbench

Parametrised control sequencer for one convolution PE. It drives the PE datapath's multiplier-select, accumulator-select and output-select lines. It runs kernel_size MAC beats per input channel over num_ch channels, with two modes: accumulate all channels into one output partial sum, or emit one per channel. Operand stalls are tolerated via in_valid, and output back-pressure via an opsum_valid/opsum_ready handshake. It sits beside each PE in the array and replaces the fixed, non-stalling single-channel controller.

---
 rtl/pe_ctrl_pkg.sv | 27 ++
 rtl/pe_loop_counter.sv | 40 ++++
 rtl/pe_mac_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pe_mac_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pe_ctrl_pkg : shared state encoding and select constants for the
//               PE MAC sequencer.  Rev 1.0
// ------------------------------------------------------------------
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MAC   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Datapath select encodings
  localparam logic SEL_IPSUM = 1'b1;
  localparam logic SEL_MULT  = 1'b0;
  localparam logic SEL_ZERO  = 1'b1;
  localparam logic SEL_PSUM  = 1'b0;
  localparam logic OPSUM_ON  = 1'b0;
  localparam logic OPSUM_OFF = 1'b1;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_CH_W  = 4;

endpackage
`default_nettype wire

// File: rtl/pe_loop_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// pe_loop_counter : loop counter with clear priority and full-width
//                   terminal-count compare.  Rev 1.0
// ------------------------------------------------------------------
module pe_loop_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic             at_term
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_term = (cnt_q == term);

endmodule
`default_nettype wire

// File: rtl/pe_mac_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// pe_mac_sequencer : stall-tolerant multi-channel MAC control FSM
//                    driving one PE's select lines.  Rev 1.0
// ------------------------------------------------------------------
module pe_mac_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int CH_W  = DEF_CH_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] kernel_size,
  input  logic [CH_W-1:0]  num_ch,
  input  logic             acc_ch,
  input  logic             in_valid,
  output logic             mac_en,
  output logic             mult_seln,
  output logic             acc_seln,
  output logic             opsum_seln,
  output logic             opsum_valid,
  input  logic             opsum_ready,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] kernel_size_q, kernel_size_d;
  logic [CH_W-1:0]  num_ch_q, num_ch_d;
  logic             acc_ch_q, acc_ch_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  logic w_cfg_ok;
  logic w_beat_acc;
  logic w_beat_last;
  logic w_ch_last;
  logic w_final_hs;
  logic w_job_accept;
  logic w_beat_en, w_beat_clr;
  logic w_ch_en, w_ch_clr;

  assign w_cfg_ok     = (kernel_size != '0) && (num_ch != '0);
  assign w_beat_acc   = (state_q == ST_MAC) && in_valid;
  assign w_final_hs   = (state_q == ST_DRAIN) && opsum_ready && w_ch_last;
  assign w_job_accept = start && w_cfg_ok && ((state_q == ST_IDLE) || w_final_hs);

  assign w_beat_en  = w_beat_acc && !w_beat_last;
  assign w_beat_clr = (w_beat_acc && w_beat_last) || w_job_accept || w_final_hs;
  // Channel advances either inside MAC (accumulate mode) or on a non-final drain handshake
  assign w_ch_en    = (w_beat_acc && w_beat_last && !w_ch_last && acc_ch_q)
                   || ((state_q == ST_DRAIN) && opsum_ready && !w_ch_last);
  assign w_ch_clr   = w_final_hs || w_job_accept;

  pe_loop_counter #(.WIDTH(CNT_W)) u_beat_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .en      (w_beat_en),
    .clr     (w_beat_clr),
    .term    (kernel_size_q - CNT_W'(1)),
    .at_term (w_beat_last)
  );

  pe_loop_counter #(.WIDTH(CH_W)) u_ch_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .en      (w_ch_en),
    .clr     (w_ch_clr),
    .term    (num_ch_q - CH_W'(1)),
    .at_term (w_ch_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      kernel_size_q <= '0;
      num_ch_q      <= '0;
      acc_ch_q      <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      kernel_size_q <= kernel_size_d;
      num_ch_q      <= num_ch_d;
      acc_ch_q      <= acc_ch_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    kernel_size_d = kernel_size_q;
    num_ch_d      = num_ch_q;
    acc_ch_d      = acc_ch_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    if (w_job_accept) begin
      kernel_size_d = kernel_size;
      num_ch_d      = num_ch;
      acc_ch_d      = acc_ch;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (w_cfg_ok) state_d = ST_LOAD;
          else          cfg_err_d = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_MAC;
      ST_MAC: begin
        if (w_beat_acc && w_beat_last && (w_ch_last || !acc_ch_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (opsum_ready) begin
          if (!w_ch_last) begin
            state_d = ST_LOAD;
          end else begin
            done_d = 1'b1;
            if (start && w_cfg_ok) begin
              state_d = ST_LOAD;
            end else begin
              state_d   = ST_IDLE;
              cfg_err_d = start;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mac_en      = 1'b0;
    mult_seln   = SEL_IPSUM;
    acc_seln    = SEL_ZERO;
    opsum_seln  = OPSUM_OFF;
    opsum_valid = 1'b0;
    busy        = 1'b1;
    case (state_q)
      ST_IDLE: busy = 1'b0;
      ST_LOAD: ;
      ST_MAC: begin
        mac_en    = in_valid;
        mult_seln = SEL_MULT;
        acc_seln  = SEL_PSUM;
      end
      ST_DRAIN: begin
        mult_seln   = SEL_MULT;
        acc_seln    = SEL_PSUM;
        opsum_seln  = OPSUM_ON;
        opsum_valid = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pe_mac_sequencer : directed + randomized bench against a
//                       segment-level behavioural model.  Rev 1.0
// ------------------------------------------------------------------
module tb_pe_mac_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] kernel_size;
  logic [3:0] num_ch;
  logic       acc_ch;
  logic       in_valid;
  logic       mac_en, mult_seln, acc_seln, opsum_seln, opsum_valid;
  logic       opsum_ready;
  logic       busy, done, cfg_err;

  always #5 clk = ~clk;

  pe_mac_sequencer #(.CNT_W(8), .CH_W(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .kernel_size (kernel_size),
    .num_ch      (num_ch),
    .acc_ch      (acc_ch),
    .in_valid    (in_valid),
    .mac_en      (mac_en),
    .mult_seln   (mult_seln),
    .acc_seln    (acc_seln),
    .opsum_seln  (opsum_seln),
    .opsum_valid (opsum_valid),
    .opsum_ready (opsum_ready),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int n_mac, n_valid, n_hs, n_done, n_load, n_err, n_idle, n_busy, n_seln0;
  int first_valid, done_at, last_hs;

  // Job viewed as segments of MAC beats, each ending in one opsum
  int m_phase;  // 0 idle, 1 load, 2 mac, 3 drain
  int m_left, m_segs, m_seg_len;
  bit m_done, m_err;

  localparam logic [7:0] RESET_OUTS = 8'b0111_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_segs = 0; m_seg_len = 0; m_done = 0; m_err = 0;
  endtask

  task automatic clear_stats();
    n_mac = 0; n_valid = 0; n_hs = 0; n_done = 0; n_load = 0; n_err = 0;
    n_idle = 0; n_busy = 0; n_seln0 = 0; first_valid = -1; done_at = -1; last_hs = -1;
  endtask

  function automatic logic [7:0] outs();
    return {busy, mult_seln, acc_seln, opsum_seln, opsum_valid, mac_en, done, cfg_err};
  endfunction

  task automatic model_try_start(input int k, input int n, input bit a, inout bit ne);
    if (k == 0 || n == 0) begin
      ne = 1;
      m_phase = 0;
    end else begin
      m_segs    = a ? 1 : n;
      m_seg_len = a ? k * n : k;
      m_left    = m_seg_len;
      m_phase   = 1;
    end
  endtask

  task automatic step(input logic s, input logic iv, input logic rdy,
                      input logic [7:0] k, input logic [3:0] n, input logic a);
    logic [7:0] exp;
    bit nd, ne;
    @(negedge clk);
    start = s; in_valid = iv; opsum_ready = rdy;
    kernel_size = k; num_ch = n; acc_ch = a;
    #1;
    case (m_phase)
      0:       exp = {1'b0, 3'b111, 1'b0, 1'b0, m_done, m_err};
      1:       exp = {1'b1, 3'b111, 1'b0, 1'b0, m_done, m_err};
      2:       exp = {1'b1, 3'b001, 1'b0, iv,   m_done, m_err};
      default: exp = {1'b1, 3'b000, 1'b1, 1'b0, m_done, m_err};
    endcase
    check("outs", outs(), exp);
    if (mac_en) n_mac++;
    if (opsum_valid) begin
      n_valid++;
      if (first_valid < 0) first_valid = cyc;
      if (rdy) begin n_hs++; last_hs = cyc; end
    end
    if (done) begin n_done++; done_at = cyc; end
    if (cfg_err) n_err++;
    if (busy) n_busy++; else n_idle++;
    if (busy && mult_seln && acc_seln && opsum_seln) n_load++;
    if (!(mult_seln && acc_seln && opsum_seln)) n_seln0++;
    nd = 0; ne = 0;
    case (m_phase)
      0: if (s) model_try_start(int'(k), int'(n), a, ne);
      1: m_phase = 2;
      2: if (iv) begin
           m_left--;
           if (m_left == 0) m_phase = 3;
         end
      default: if (rdy) begin
        m_segs--;
        if (m_segs > 0) begin
          m_phase = 1;
          m_left  = m_seg_len;
        end else begin
          nd = 1;
          m_phase = 0;
          if (s) model_try_start(int'(k), int'(n), a, ne);
        end
      end
    endcase
    m_done = nd; m_err = ne;
    cyc++;
  endtask

  task automatic run_idle(input logic iv, input logic rdy);
    int guard = 0;
    while (!(m_phase == 0 && !m_done && !m_err) && guard < 5000) begin
      step(1'b0, iv, rdy, 8'd0, 4'd0, 1'b0);
      guard++;
    end
    if (guard >= 5000) check("idle_timeout", m_phase, 0);
  endtask

  initial begin
    int t0, stall, guard;
    logic iv, rdy;
    rstn = 1'b0; start = 0; kernel_size = 0; num_ch = 0; acc_ch = 0;
    in_valid = 0; opsum_ready = 0;
    model_reset();
    clear_stats();
    repeat (2) @(negedge clk);
    #1 check("reset_outs", outs(), RESET_OUTS);
    @(negedge clk) rstn = 1'b1;

    // Single job, k=3 n=1
    clear_stats(); t0 = cyc;
    step(1, 1, 1, 8'd3, 4'd1, 1);
    run_idle(1, 1);
    check("single_valid_lat", first_valid - t0, 5);
    check("single_done_lat", done_at - t0, 6);
    check("single_done_cnt", n_done, 1);

    // Multi-channel accumulate
    clear_stats();
    step(1, 1, 1, 8'd2, 4'd3, 1);
    run_idle(1, 1);
    check("acc_loads", n_load, 1);
    check("acc_beats", n_mac, 6);
    check("acc_hs", n_hs, 1);
    check("acc_done", n_done, 1);

    // Per-channel
    clear_stats();
    step(1, 1, 1, 8'd2, 4'd3, 0);
    run_idle(1, 1);
    check("perch_loads", n_load, 3);
    check("perch_beats", n_mac, 6);
    check("perch_hs", n_hs, 3);
    check("perch_done", n_done, 1);
    check("perch_done_after_last", done_at - last_hs, 1);

    // Operand stall and output back-pressure
    clear_stats(); stall = 0; guard = 0;
    step(1, 1, 1, 8'd4, 4'd1, 1);
    while (!(m_phase == 0 && !m_done) && guard < 100) begin
      iv = 1'b1;
      if (m_phase == 2 && n_mac == 2 && stall < 2) begin iv = 1'b0; stall++; end
      rdy = (n_valid >= 3);
      step(0, iv, rdy, 8'd0, 4'd0, 0);
      guard++;
    end
    check("stall_guard", guard < 100, 1);
    check("stall_beats", n_mac, 4);
    check("stall_valid_len", n_valid, 4);
    check("stall_done", n_done, 1);

    // Configuration errors
    clear_stats();
    step(1, 1, 1, 8'd0, 4'd2, 1);
    step(0, 1, 1, 8'd0, 4'd0, 0);
    step(1, 1, 1, 8'd5, 4'd0, 0);
    step(0, 1, 1, 8'd0, 4'd0, 0);
    step(0, 1, 1, 8'd0, 4'd0, 0);
    check("cfg_err_cnt", n_err, 2);
    check("cfg_busy", n_busy, 0);
    check("cfg_seln", n_seln0, 0);

    // Asynchronous reset in the middle of MAC
    clear_stats();
    step(1, 1, 1, 8'd5, 4'd2, 1);
    repeat (3) step(0, 1, 1, 8'd0, 4'd0, 0);
    #2 rstn = 1'b0;
    #1 check("async_reset", outs(), RESET_OUTS);
    model_reset();
    clear_stats();
    @(negedge clk) rstn = 1'b1;
    repeat (5) step(0, 1, 1, 8'd0, 4'd0, 0);
    check("post_reset_done", n_done, 0);
    check("post_reset_busy", n_busy, 0);

    // Back-to-back jobs with start held
    clear_stats(); guard = 0;
    step(1, 1, 1, 8'd2, 4'd1, 1);
    n_idle = 0;
    while (n_done < 2 && guard < 40) begin
      step(1, 1, 1, 8'd2, 4'd1, 1);
      guard++;
    end
    check("b2b_done", n_done, 2);
    check("b2b_no_idle", n_idle, 0);
    run_idle(1, 1);

    // Largest legal kernel
    clear_stats();
    step(1, 1, 1, 8'd255, 4'd1, 1);
    run_idle(1, 1);
    check("max_kernel_beats", n_mac, 255);
    check("max_kernel_done", n_done, 1);

    // Randomized traffic; config inputs change freely to exercise latching
    clear_stats();
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] rk;
      logic [3:0] rn;
      rk = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
      rn = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
      step(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 9) < 7),
           logic'($urandom_range(0, 9) < 6), rk, rn, logic'($urandom_range(0, 1)));
    end
    run_idle(1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
